// File: rtl/decomp_dispatcher.sv
// decomp_dispatcher
//   Host-side scheduler sharing CORES decompression cores between successive
//   compressed pages. Each page is a 32-bit header {uncom_size, com_size}
//   followed by its body. Bodies are dispatched round-robin to the cores, and
//   the core outputs are re-serialised to the host in dispatch order. Byte
//   counts are checked against the header on both sides.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   s_t*               host input stream (header beat, then body beats)
//   c_in_t*            body stream shared by all cores, per-core valid/ready
//   c_out_t*           per-core output streams, core i at slice i
//   m_t*               host output stream (decompressed pages, in order)
//   err_hdr            pulse: malformed header discarded
//   err_len            pulse: body byte count differs from com_size
//   err_size           pulse: output byte count differs from uncom_size
//   pages_done         completed output pages, wraps
module decomp_dispatcher #(
    parameter int CORES       = 4,
    parameter int DATA_BITS   = 512,
    parameter int SIZE_W      = 16,
    parameter int ORDER_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_BITS-1:0]           s_tdata,
    input  logic [DATA_BITS/8-1:0]         s_tkeep,
    input  logic                           s_tlast,
    input  logic                           s_tvalid,
    output logic                           s_tready,
    output logic [DATA_BITS-1:0]           c_in_tdata,
    output logic [DATA_BITS/8-1:0]         c_in_tkeep,
    output logic                           c_in_tlast,
    output logic [CORES-1:0]               c_in_tvalid,
    input  logic [CORES-1:0]               c_in_tready,
    input  logic [CORES*DATA_BITS-1:0]     c_out_tdata,
    input  logic [CORES*DATA_BITS/8-1:0]   c_out_tkeep,
    input  logic [CORES-1:0]               c_out_tlast,
    input  logic [CORES-1:0]               c_out_tvalid,
    output logic [CORES-1:0]               c_out_tready,
    output logic [DATA_BITS-1:0]           m_tdata,
    output logic [DATA_BITS/8-1:0]         m_tkeep,
    output logic                           m_tlast,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           err_hdr,
    output logic                           err_len,
    output logic                           err_size,
    output logic [31:0]                    pages_done
);

    localparam int KEEP_W = DATA_BITS / 8;
    localparam int PTR_W  = (CORES > 1) ? $clog2(CORES) : 1;
    localparam int OA_W   = $clog2(ORDER_DEPTH);
    localparam int OC_W   = OA_W + 1;
    localparam int CNT_W  = SIZE_W + 1;
    localparam int SUM_W  = CNT_W + 1;
    localparam int PC_W   = $clog2(KEEP_W + 1);

    typedef enum logic [0:0] {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } in_state_t;

    // Number of enabled bytes in a beat.
    function automatic logic [PC_W-1:0] popcount(input logic [KEEP_W-1:0] keep);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + PC_W'(keep[i]);
        end
        return n;
    endfunction

    // Byte counter add that sticks at all-ones instead of wrapping, so an
    // oversized page can never alias back to a matching length.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [PC_W-1:0]  inc);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, cnt} + SUM_W'(inc);
        if (sum[SUM_W-1]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    // Round-robin core pointer advance.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(CORES - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    in_state_t             in_state_r;
    in_state_t             in_state_nxt_s;
    logic [PTR_W-1:0]      in_ptr_r;
    logic [PTR_W-1:0]      out_ptr_r;
    logic [CNT_W-1:0]      in_cnt_r;
    logic [CNT_W-1:0]      out_cnt_r;
    logic [SIZE_W-1:0]     exp_com_r;
    logic                  err_hdr_r;
    logic                  err_len_r;
    logic                  err_size_r;
    logic [31:0]           pages_done_r;

    logic [SIZE_W-1:0]     order_mem [ORDER_DEPTH];
    logic [OA_W-1:0]       wr_ptr_r;
    logic [OA_W-1:0]       rd_ptr_r;
    logic [OC_W-1:0]       order_cnt_r;
    logic                  order_full_s;
    logic                  order_empty_s;
    logic [SIZE_W-1:0]     order_head_s;

    logic [SIZE_W-1:0]     hdr_uncom_s;
    logic [SIZE_W-1:0]     hdr_com_s;
    logic                  s_ready_s;
    logic [CORES-1:0]      c_in_valid_s;
    logic                  push_s;
    logic                  hdr_err_s;
    logic                  in_acc_s;
    logic [CNT_W-1:0]      in_sum_s;

    logic [CORES-1:0]      c_out_ready_s;
    logic                  m_valid_s;
    logic                  m_acc_s;
    logic                  pop_s;
    logic [CNT_W-1:0]      out_sum_s;

    assign hdr_uncom_s   = s_tdata[2*SIZE_W-1:SIZE_W];
    assign hdr_com_s     = s_tdata[SIZE_W-1:0];
    assign order_full_s  = (order_cnt_r == OC_W'(ORDER_DEPTH));
    assign order_empty_s = (order_cnt_r == {OC_W{1'b0}});
    assign order_head_s  = order_mem[rd_ptr_r];
    assign in_sum_s      = sat_add(in_cnt_r, popcount(s_tkeep));

    // Body stream is a pure pass-through; only the valid is steered.
    assign c_in_tdata = s_tdata;
    assign c_in_tkeep = s_tkeep;
    assign c_in_tlast = s_tlast;

    // Handshakes are held off while reset is asserted.
    assign s_tready    = rst_n & s_ready_s;
    assign c_in_tvalid = rst_n ? c_in_valid_s : {CORES{1'b0}};

    // Input FSM: next state, ready steering and header decode.
    always_comb begin
        in_state_nxt_s = in_state_r;
        s_ready_s      = 1'b0;
        c_in_valid_s   = {CORES{1'b0}};
        push_s         = 1'b0;
        hdr_err_s      = 1'b0;
        in_acc_s       = 1'b0;
        case (in_state_r)
            ST_HDR: begin
                s_ready_s = !order_full_s;
                if (s_tvalid && s_ready_s) begin
                    // A header with no body, or one that claims to be the
                    // last beat, cannot start a page.
                    if ((hdr_com_s == {SIZE_W{1'b0}}) || s_tlast) begin
                        hdr_err_s = 1'b1;
                    end else begin
                        push_s         = 1'b1;
                        in_state_nxt_s = ST_BODY;
                    end
                end else begin
                    in_state_nxt_s = ST_HDR;
                end
            end
            ST_BODY: begin
                c_in_valid_s[in_ptr_r] = s_tvalid;
                s_ready_s              = c_in_tready[in_ptr_r];
                in_acc_s               = s_tvalid && s_ready_s;
                if (in_acc_s && s_tlast) begin
                    in_state_nxt_s = ST_HDR;
                end else begin
                    in_state_nxt_s = ST_BODY;
                end
            end
            default: begin
                in_state_nxt_s = ST_HDR;
            end
        endcase
    end

    // Input FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_state_r <= ST_HDR;
        end else begin
            in_state_r <= in_state_nxt_s;
        end
    end

    // Input byte accounting, dispatch pointer, header/length error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ptr_r  <= {PTR_W{1'b0}};
            in_cnt_r  <= {CNT_W{1'b0}};
            exp_com_r <= {SIZE_W{1'b0}};
            err_hdr_r <= 1'b0;
            err_len_r <= 1'b0;
        end else begin
            err_hdr_r <= hdr_err_s;
            err_len_r <= 1'b0;
            if (push_s) begin
                exp_com_r <= hdr_com_s;
                in_cnt_r  <= {CNT_W{1'b0}};
            end else if (in_acc_s) begin
                if (s_tlast) begin
                    err_len_r <= (in_sum_s != {1'b0, exp_com_r});
                    in_ptr_r  <= next_ptr(in_ptr_r);
                    in_cnt_r  <= {CNT_W{1'b0}};
                end else begin
                    in_cnt_r  <= in_sum_s;
                end
            end else begin
                in_cnt_r <= in_cnt_r;
            end
        end
    end

    // Order FIFO storage: expected uncompressed size per page in flight.
    always_ff @(posedge clk) begin
        if (push_s) begin
            order_mem[wr_ptr_r] <= hdr_uncom_s;
        end
    end

    // Order FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= {OA_W{1'b0}};
            rd_ptr_r    <= {OA_W{1'b0}};
            order_cnt_r <= {OC_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + OA_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + OA_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   order_cnt_r <= order_cnt_r + OC_W'(1);
                2'b01:   order_cnt_r <= order_cnt_r - OC_W'(1);
                default: order_cnt_r <= order_cnt_r;
            endcase
        end
    end

    // Output mux: only the core owning the oldest page in flight is heard.
    assign m_tdata   = c_out_tdata[out_ptr_r*DATA_BITS +: DATA_BITS];
    assign m_tkeep   = c_out_tkeep[out_ptr_r*KEEP_W +: KEEP_W];
    assign m_tlast   = c_out_tlast[out_ptr_r];
    assign m_valid_s = c_out_tvalid[out_ptr_r] && !order_empty_s;
    assign m_tvalid  = rst_n & m_valid_s;
    assign c_out_tready = rst_n ? c_out_ready_s : {CORES{1'b0}};
    assign m_acc_s   = m_tvalid && m_tready;
    assign pop_s     = m_acc_s && m_tlast;
    assign out_sum_s = sat_add(out_cnt_r, popcount(m_tkeep));

    // Core output ready: non-current cores are stalled.
    always_comb begin
        c_out_ready_s = {CORES{1'b0}};
        if (!order_empty_s) begin
            c_out_ready_s[out_ptr_r] = m_tready;
        end else begin
            c_out_ready_s = {CORES{1'b0}};
        end
    end

    // Output byte accounting, reorder pointer, size error and page count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_ptr_r    <= {PTR_W{1'b0}};
            out_cnt_r    <= {CNT_W{1'b0}};
            err_size_r   <= 1'b0;
            pages_done_r <= 32'd0;
        end else begin
            err_size_r <= 1'b0;
            if (m_acc_s) begin
                if (m_tlast) begin
                    err_size_r   <= (out_sum_s != {1'b0, order_head_s});
                    out_cnt_r    <= {CNT_W{1'b0}};
                    pages_done_r <= pages_done_r + 32'd1;
                    out_ptr_r    <= next_ptr(out_ptr_r);
                end else begin
                    out_cnt_r <= out_sum_s;
                end
            end else begin
                out_cnt_r <= out_cnt_r;
            end
        end
    end

    assign err_hdr    = err_hdr_r;
    assign err_len    = err_len_r;
    assign err_size   = err_size_r;
    assign pages_done = pages_done_r;

endmodule

// File: doc/decomp_dispatcher.md
Name: decomp_dispatcher

Overview:
- Host-side scheduler that shares CORES decompression cores between successive compressed pages.
- Parses the 32-bit page header {uncom_size, com_size} that precedes each compressed page body.
- Dispatches bodies round-robin to the cores, then re-serialises core outputs to the host in dispatch order.
- Checks compressed and decompressed byte counts against the header and reports mismatches.

Parameters:
CORES, 4, number of decompression cores (>=2)
DATA_BITS, 512, stream data width
SIZE_W, 16, width of each header size field
ORDER_DEPTH, 8, pages in flight (header accepted, output not finished); power of two, >= CORES

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
s_tdata  in  DATA_BITS  host input data
s_tkeep  in  DATA_BITS/8  byte enables
s_tlast  in  1  last body beat of page
s_tvalid  in  1  input valid
s_tready  out  1  input ready
c_in_tdata  out  DATA_BITS  body data, shared by all cores
c_in_tkeep  out  DATA_BITS/8  shared byte enables
c_in_tlast  out  1  shared last
c_in_tvalid  out  CORES  per-core valid
c_in_tready  in  CORES  per-core ready
c_out_tdata  in  CORES*DATA_BITS  core outputs, core i at slice i
c_out_tkeep  in  CORES*DATA_BITS/8  core output byte enables
c_out_tlast  in  CORES  core output last
c_out_tvalid  in  CORES  core output valid
c_out_tready  out  CORES  core output ready
m_tdata  out  DATA_BITS  host output data
m_tkeep  out  DATA_BITS/8  host output byte enables
m_tlast  out  1  last beat of decompressed page
m_tvalid  out  1  host output valid
m_tready  in  1  host output ready
err_hdr  out  1  one-cycle pulse: malformed header discarded
err_len  out  1  one-cycle pulse: body bytes != com_size
err_size  out  1  one-cycle pulse: output bytes != uncom_size
pages_done  out  32  count of completed output pages, wraps

Behaviour:
- Reset (rst_n low at posedge): in_state=HDR, in_ptr=0, out_ptr=0, order FIFO empty, byte counters 0, pages_done 0, err_* 0.
- While rst_n is low: s_tready, c_in_tvalid, c_out_tready and m_tvalid are forced 0.
- Reset mid-page abandons that page; no error pulses are raised for it.
- Both paths are combinational pass-through with zero added latency. A beat transfers when valid && ready.
- Header beat format: tdata[31:16]=uncom_size, tdata[15:0]=com_size. Other bits and tkeep are ignored.
- Input FSM, state HDR:
  - s_tready = !order_full.
  - On an accepted beat with com_size==0 or tlast==1: err_hdr pulse, beat discarded, stay in HDR, in_ptr unchanged.
  - Otherwise: push uncom_size into the order FIFO, load exp_com=com_size, clear in_cnt, go to BODY.
- Input FSM, state BODY:
  - c_in_* mirror s_*. c_in_tvalid[in_ptr]=s_tvalid; all other bits 0.
  - s_tready = c_in_tready[in_ptr].
  - Each accepted beat adds popcount(s_tkeep) to in_cnt. in_cnt is SIZE_W+1 bits and saturates at all-ones.
  - On accepted tlast: err_len pulse if in_cnt + popcount != exp_com; in_ptr advances (CORES-1 wraps to 0); go to HDR.
  - A length error does not stop the page; it is still forwarded and expected at the output.
- Output path:
  - m_* mirror core out_ptr. m_tvalid = c_out_tvalid[out_ptr] && !order_empty.
  - c_out_tready[out_ptr] = m_tready && !order_empty; all other bits 0. Non-current cores are stalled.
  - Each accepted beat adds popcount(m_tkeep) to out_cnt (same saturation rule as in_cnt).
  - On accepted m_tlast: err_size pulse if the total != order FIFO head; pop the FIFO; clear out_cnt; pages_done+1; out_ptr advances with wrap.
- Order FIFO push and pop in the same cycle: occupancy is unchanged. A push while full cannot occur because s_tready is low.
- Error pulses last exactly one cycle. err_len and err_size may assert in the same cycle.

Test Plan:
- Single page: header uncom=256, com=128; two full-keep body beats to core0. Core0 returns four beats -> m sees 4 beats with tlast on the 4th, pages_done=1, no err_*, in_ptr=out_ptr=1.
- Round-robin order, CORES=4, five pages: bodies go to cores 0,1,2,3,0. Core2 output arrives first but is held (c_out_tready[2]=0) -> host receives pages in order 0,1,2,3,0.
- Header com=100, body 128 bytes -> err_len pulses on the tlast beat; page is still delivered; in_ptr advances.
- Header com_size=0, then header with tlast=1 -> two err_hdr pulses; c_in_tvalid stays 0; order FIFO empty; in_ptr=0.
- ORDER_DEPTH=8 with all cores holding output: 9th header sees s_tready=0 until the first m_tlast pop; it is accepted the cycle after.
- Core returns 200 bytes for uncom=256 -> err_size pulse at m_tlast. Reset asserted mid-BODY -> all outputs 0 during reset; next header is dispatched to core0.
